ex_muldiv_unit: RTL and testbench

- Parametrised, self-contained multiply/divide unit for the EX stage.
- Replaces the fixed 32-bit EX multiplier and the external-IP divider handshake with one in-house block:
  - pipelined multiplier;
  - iterative restoring divider with a configurable number of bits per cycle.
- EX issues one request over a valid/ready handshake and stalls until the result handshake completes.
- `flush` (exception/ertn) cancels any in-flight operation.

---
 rtl/muldiv_pkg.sv | 35 +++
 rtl/ex_muldiv_unit_if.sv | 23 ++
 rtl/muldiv_div_core.sv | 97 +++++++++
 rtl/ex_muldiv_unit.sv | 187 ++++++++++++++++++
 tb/tb_ex_muldiv_unit.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/muldiv_pkg.sv
// Shared encodings for the EX-stage multiply/divide unit: op codes, FSM states, helpers.
package muldiv_pkg;

    localparam int unsigned MULDIV_OP_W = 3;
    localparam int unsigned MUL_CNT_W   = 2;

    localparam logic [MULDIV_OP_W-1:0] MULDIV_OP_MUL   = 3'd0;
    localparam logic [MULDIV_OP_W-1:0] MULDIV_OP_MULH  = 3'd1;
    localparam logic [MULDIV_OP_W-1:0] MULDIV_OP_MULHU = 3'd2;
    localparam logic [MULDIV_OP_W-1:0] MULDIV_OP_DIV   = 3'd3;
    localparam logic [MULDIV_OP_W-1:0] MULDIV_OP_MOD   = 3'd4;
    localparam logic [MULDIV_OP_W-1:0] MULDIV_OP_DIVU  = 3'd5;
    localparam logic [MULDIV_OP_W-1:0] MULDIV_OP_MODU  = 3'd6;
    localparam logic [MULDIV_OP_W-1:0] MULDIV_OP_RSVD  = 3'd7;

    typedef enum logic [1:0] {
        StIdle,
        StMul,
        StDiv,
        StDone
    } muldiv_state_e;

    function automatic logic is_div_op(input logic [MULDIV_OP_W-1:0] op);
        return (op >= MULDIV_OP_DIV) && (op <= MULDIV_OP_MODU);
    endfunction

    function automatic logic is_signed_div(input logic [MULDIV_OP_W-1:0] op);
        return (op == MULDIV_OP_DIV) || (op == MULDIV_OP_MOD);
    endfunction

    function automatic logic is_rem_op(input logic [MULDIV_OP_W-1:0] op);
        return (op == MULDIV_OP_MOD) || (op == MULDIV_OP_MODU);
    endfunction

endpackage

// File: rtl/ex_muldiv_unit_if.sv
// Request/response handshake between the EX stage (master) and the mul/div unit (slave).
interface ex_muldiv_unit_if #(
    parameter int unsigned WIDTH = 32
);
    logic             req_valid;
    logic             req_ready;
    logic [2:0]       req_op;
    logic [WIDTH-1:0] req_src1;
    logic [WIDTH-1:0] req_src2;
    logic             resp_valid;
    logic             resp_ready;
    logic [WIDTH-1:0] resp_result;

    modport master (
        output req_valid, req_op, req_src1, req_src2, resp_ready,
        input  req_ready, resp_valid, resp_result
    );

    modport slave (
        input  req_valid, req_op, req_src1, req_src2, resp_ready,
        output req_ready, resp_valid, resp_result
    );
endinterface

// File: rtl/muldiv_div_core.sv
// Iterative unsigned restoring divider resolving DIV_BITS quotient bits per cycle.
module muldiv_div_core
    import muldiv_pkg::*;
#(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned DIV_BITS = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic             done_o,
    output logic [WIDTH-1:0] quotient_o,
    output logic [WIDTH-1:0] remainder_o
);
    localparam int unsigned Iters = WIDTH / DIV_BITS;
    localparam int unsigned CntW  = $clog2(Iters) + 1;

    logic [WIDTH-1:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             active_q, active_d, done_q, done_d;

    logic [WIDTH-1:0] rem_w, quo_w;
    logic [WIDTH:0]   rem_x, trial;

    always_comb begin
        rem_w = rem_q;
        quo_w = quo_q;
        rem_x = '0;
        trial = '0;
        for (int i = 0; i < DIV_BITS; i++) begin
            rem_x = {rem_w, quo_w[WIDTH-1]};
            quo_w = {quo_w[WIDTH-2:0], 1'b0};
            trial = rem_x - {1'b0, dvs_q};
            // Borrow out means the divisor did not fit: keep the shifted remainder.
            if (trial[WIDTH]) begin
                rem_w = rem_x[WIDTH-1:0];
            end else begin
                rem_w    = trial[WIDTH-1:0];
                quo_w[0] = 1'b1;
            end
        end
    end

    always_comb begin
        rem_d    = rem_q;
        quo_d    = quo_q;
        dvs_d    = dvs_q;
        cnt_d    = cnt_q;
        active_d = active_q;
        done_d   = done_q;
        if (flush_i) begin
            active_d = 1'b0;
            done_d   = 1'b0;
        end else if (start_i) begin
            rem_d    = '0;
            quo_d    = dividend_i;
            dvs_d    = divisor_i;
            cnt_d    = '0;
            active_d = 1'b1;
            done_d   = 1'b0;
        end else if (active_q) begin
            rem_d = rem_w;
            quo_d = quo_w;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CntW'(Iters - 1)) begin
                active_d = 1'b0;
                done_d   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rem_q    <= '0;
            quo_q    <= '0;
            dvs_q    <= '0;
            cnt_q    <= '0;
            active_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            dvs_q    <= dvs_d;
            cnt_q    <= cnt_d;
            active_q <= active_d;
            done_q   <= done_d;
        end
    end

    assign done_o      = done_q;
    assign quotient_o  = quo_q;
    assign remainder_o = rem_q;

endmodule

// File: rtl/ex_muldiv_unit.sv
// EX-stage multiply/divide unit: pipelined multiplier plus iterative restoring divider.
// Define MULDIV_EARLY_OUT_EN to finish divides with |dividend| < |divisor| in one cycle.
module ex_muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned MUL_STAGES = 2,
    parameter int unsigned DIV_BITS   = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    output logic            busy,
    ex_muldiv_unit_if.slave bus
);
    localparam int unsigned ProdW     = 2 * WIDTH;
    localparam int unsigned PipeDepth = (MUL_STAGES > 1) ? MUL_STAGES - 1 : 1;

    muldiv_state_e          state_q, state_d;
    logic [MULDIV_OP_W-1:0] op_q, op_d, op_in;
    logic [WIDTH-1:0]       src1_q, src1_d, src2_q, src2_d;
    logic [MUL_CNT_W-1:0]   mul_cnt_q, mul_cnt_d;
    logic                   early_q, early_d, dz_q, dz_d;
    logic                   quo_neg_q, quo_neg_d, rem_neg_q, rem_neg_d;
    logic                   resp_valid_q, resp_valid_d;
    logic [WIDTH-1:0]       resp_result_q, resp_result_d;
    logic [ProdW-1:0]       mul_pipe_q [PipeDepth];
    logic [ProdW-1:0]       mul_pipe_d [PipeDepth];

    logic             accept, in_div, in_signed, div_zero, early_in, div_start, div_done;
    logic             mul_signed;
    logic [WIDTH-1:0] abs1, abs2, div_quo, div_rem, mul_result, div_result;
    logic [ProdW-1:0] mul_a, mul_b, mul_prod, mul_final;

    // Request decode; operands are only looked at in the accepting cycle.
    always_comb begin
        op_in     = (bus.req_op == MULDIV_OP_RSVD) ? MULDIV_OP_MUL : bus.req_op;
        in_div    = is_div_op(op_in);
        in_signed = is_signed_div(op_in);
        abs1      = (in_signed && bus.req_src1[WIDTH-1]) ? -bus.req_src1 : bus.req_src1;
        abs2      = (in_signed && bus.req_src2[WIDTH-1]) ? -bus.req_src2 : bus.req_src2;
        div_zero  = (bus.req_src2 == '0);
`ifdef MULDIV_EARLY_OUT_EN
        early_in  = div_zero || (abs1 < abs2);
`else
        early_in  = div_zero;
`endif
        accept    = bus.req_valid && (state_q == StIdle) && !flush;
        div_start = accept && in_div && !early_in;
    end

    muldiv_div_core #(
        .WIDTH    (WIDTH),
        .DIV_BITS (DIV_BITS)
    ) u_div_core (
        .clk         (clk),
        .reset       (reset),
        .flush_i     (flush),
        .start_i     (div_start),
        .dividend_i  (abs1),
        .divisor_i   (abs2),
        .done_o      (div_done),
        .quotient_o  (div_quo),
        .remainder_o (div_rem)
    );

    // Sign/zero extension to 2*WIDTH makes the truncated product exact for both signednesses.
    always_comb begin
        mul_signed    = (op_q != MULDIV_OP_MULHU);
        mul_a         = {{WIDTH{mul_signed & src1_q[WIDTH-1]}}, src1_q};
        mul_b         = {{WIDTH{mul_signed & src2_q[WIDTH-1]}}, src2_q};
        mul_prod      = mul_a * mul_b;
        mul_pipe_d[0] = mul_prod;
        for (int i = 1; i < PipeDepth; i++) begin
            mul_pipe_d[i] = mul_pipe_q[i-1];
        end
        mul_final  = (MUL_STAGES == 1) ? mul_prod : mul_pipe_q[PipeDepth-1];
        mul_result = (op_q == MULDIV_OP_MUL) ? mul_final[WIDTH-1:0] : mul_final[ProdW-1:WIDTH];
    end

    always_comb begin
        if (early_q) begin
            div_result = is_rem_op(op_q) ? src1_q : (dz_q ? {WIDTH{1'b1}} : '0);
        end else if (is_rem_op(op_q)) begin
            div_result = rem_neg_q ? -div_rem : div_rem;
        end else begin
            div_result = quo_neg_q ? -div_quo : div_quo;
        end
    end

    always_comb begin
        state_d       = state_q;
        op_d          = op_q;
        src1_d        = src1_q;
        src2_d        = src2_q;
        mul_cnt_d     = mul_cnt_q;
        early_d       = early_q;
        dz_d          = dz_q;
        quo_neg_d     = quo_neg_q;
        rem_neg_d     = rem_neg_q;
        resp_valid_d  = resp_valid_q;
        resp_result_d = resp_result_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    op_d      = op_in;
                    src1_d    = bus.req_src1;
                    src2_d    = bus.req_src2;
                    mul_cnt_d = '0;
                    early_d   = in_div && early_in;
                    dz_d      = div_zero;
                    quo_neg_d = in_signed && (bus.req_src1[WIDTH-1] ^ bus.req_src2[WIDTH-1]);
                    rem_neg_d = in_signed && bus.req_src1[WIDTH-1];
                    state_d   = in_div ? StDiv : StMul;
                end
            end
            StMul: begin
                if (mul_cnt_q == MUL_CNT_W'(MUL_STAGES - 1)) begin
                    state_d       = StDone;
                    resp_valid_d  = 1'b1;
                    resp_result_d = mul_result;
                end else begin
                    mul_cnt_d = mul_cnt_q + 1'b1;
                end
            end
            StDiv: begin
                // The cycle after the core finishes doubles as the sign-fix cycle.
                if (early_q || div_done) begin
                    state_d       = StDone;
                    resp_valid_d  = 1'b1;
                    resp_result_d = div_result;
                end
            end
            StDone: begin
                if (bus.resp_ready) begin
                    state_d      = StIdle;
                    resp_valid_d = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase
        if (flush) begin
            state_d      = StIdle;
            resp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= StIdle;
            op_q          <= MULDIV_OP_MUL;
            src1_q        <= '0;
            src2_q        <= '0;
            mul_cnt_q     <= '0;
            early_q       <= 1'b0;
            dz_q          <= 1'b0;
            quo_neg_q     <= 1'b0;
            rem_neg_q     <= 1'b0;
            resp_valid_q  <= 1'b0;
            resp_result_q <= '0;
        end else begin
            state_q       <= state_d;
            op_q          <= op_d;
            src1_q        <= src1_d;
            src2_q        <= src2_d;
            mul_cnt_q     <= mul_cnt_d;
            early_q       <= early_d;
            dz_q          <= dz_d;
            quo_neg_q     <= quo_neg_d;
            rem_neg_q     <= rem_neg_d;
            resp_valid_q  <= resp_valid_d;
            resp_result_q <= resp_result_d;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < PipeDepth; i++) begin
            mul_pipe_q[i] <= mul_pipe_d[i];
        end
    end

    assign bus.req_ready   = (state_q == StIdle);
    assign bus.resp_valid  = resp_valid_q;
    assign bus.resp_result = resp_result_q;
    assign busy            = (state_q != StIdle);

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed bench for ex_muldiv_unit: dut0 (MUL_STAGES=2, DIV_BITS=1), dut1 (MUL_STAGES=3, DIV_BITS=2).
module tb_ex_muldiv_unit;
    import muldiv_pkg::*;

`ifdef MULDIV_EARLY_OUT_EN
    localparam int EarlyLat0 = 1;
    localparam int EarlyLat1 = 1;
`else
    localparam int EarlyLat0 = 33;
    localparam int EarlyLat1 = 17;
`endif

    logic clk = 1'b0;
    logic reset, flush0, flush1, busy0, busy1;

    ex_muldiv_unit_if #(.WIDTH(32)) bus0 ();
    ex_muldiv_unit_if #(.WIDTH(32)) bus1 ();

    ex_muldiv_unit #(.WIDTH(32), .MUL_STAGES(2), .DIV_BITS(1)) dut0 (
        .clk(clk), .reset(reset), .flush(flush0), .busy(busy0), .bus(bus0.slave)
    );
    ex_muldiv_unit #(.WIDTH(32), .MUL_STAGES(3), .DIV_BITS(2)) dut1 (
        .clk(clk), .reset(reset), .flush(flush1), .busy(busy1), .bus(bus1.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          dut;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;
    vec_t vecs[$];

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input int d, input logic v, input logic [2:0] op,
                         input logic [31:0] a, input logic [31:0] b);
        if (d == 0) begin
            bus0.req_valid = v; bus0.req_op = op; bus0.req_src1 = a; bus0.req_src2 = b;
        end else begin
            bus1.req_valid = v; bus1.req_op = op; bus1.req_src1 = a; bus1.req_src2 = b;
        end
    endtask

    task automatic set_rr(input int d, input logic r);
        if (d == 0) bus0.resp_ready = r;
        else bus1.resp_ready = r;
    endtask

    // which: 0 req_ready, 1 resp_valid, 2 resp_result, 3 busy
    function automatic logic [31:0] rd(input int d, input int which);
        if (d == 0) begin
            case (which)
                0: return {31'd0, bus0.req_ready};
                1: return {31'd0, bus0.resp_valid};
                2: return bus0.resp_result;
                default: return {31'd0, busy0};
            endcase
        end
        case (which)
            0: return {31'd0, bus1.req_ready};
            1: return {31'd0, bus1.resp_valid};
            2: return bus1.resp_result;
            default: return {31'd0, busy1};
        endcase
    endfunction

    task automatic add(input int d, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] e, input int lat);
        vec_t v;
        v.dut = d; v.op = op; v.a = a; v.b = b; v.exp = e; v.lat = lat;
        vecs.push_back(v);
    endtask

    // Waits (bounded) for resp_valid; k = edges after acceptance edge.
    task automatic wait_resp(input int d, output int k);
        k = 0;
        while (rd(d, 1) == 32'd0 && k < 100) begin
            @(negedge clk);
            k++;
        end
    endtask

    task automatic run_op(input int d, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int lat,
                          input string name);
        int k;
        @(negedge clk);
        check({name, " ready"}, rd(d, 0), 32'd1);
        drive(d, 1'b1, op, a, b);
        @(negedge clk);
        drive(d, 1'b0, MULDIV_OP_MUL, 32'hDEADBEEF, 32'hDEADBEEF);
        wait_resp(d, k);
        check({name, " latency"}, k, lat);
        check({name, " result"}, rd(d, 2), exp);
        set_rr(d, 1'b1);
        @(negedge clk);
        set_rr(d, 1'b0);
        check({name, " valid drop"}, rd(d, 1), 32'd0);
    endtask

    initial begin
        int k;
        int seen;
        logic [31:0] held;

        reset = 1'b1; flush0 = 1'b0; flush1 = 1'b0;
        drive(0, 1'b0, MULDIV_OP_MUL, '0, '0);
        drive(1, 1'b0, MULDIV_OP_MUL, '0, '0);
        set_rr(0, 1'b0); set_rr(1, 1'b0);
        repeat (3) @(negedge clk);
        check("rst ready", rd(0, 0), 32'd1);
        check("rst valid", rd(0, 1), 32'd0);
        check("rst result", rd(0, 2), 32'd0);
        check("rst busy", rd(0, 3), 32'd0);
        check("rst busy1", rd(1, 3), 32'd0);
        reset = 1'b0;

        add(0, MULDIV_OP_MUL,   32'hFFFFFFFE, 32'd3,        32'hFFFFFFFA, 2);
        add(0, MULDIV_OP_MULH,  32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 2);
        add(0, MULDIV_OP_MULHU, 32'hFFFFFFFE, 32'd3,        32'h00000002, 2);
        add(0, MULDIV_OP_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 2);
        add(0, MULDIV_OP_MULH,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 2);
        add(0, MULDIV_OP_RSVD,  32'd6,        32'd7,        32'd42,       2);
        add(0, MULDIV_OP_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33);
        add(0, MULDIV_OP_MOD,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33);
        add(0, MULDIV_OP_DIVU,  32'hFFFFFFF9, 32'd2,        32'h7FFFFFFC, 33);
        add(0, MULDIV_OP_DIV,   32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 33);
        add(0, MULDIV_OP_MOD,   32'd7,        32'hFFFFFFFE, 32'h00000001, 33);
        add(0, MULDIV_OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h80000000, 33);
        add(0, MULDIV_OP_MOD,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 33);
        add(0, MULDIV_OP_DIVU,  32'd5,        32'd0,        32'hFFFFFFFF, 1);
        add(0, MULDIV_OP_MODU,  32'd5,        32'd0,        32'd5,        1);
        add(0, MULDIV_OP_DIV,   32'hFFFFFFFB, 32'd0,        32'hFFFFFFFF, 1);
        add(0, MULDIV_OP_MOD,   32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 1);
        add(0, MULDIV_OP_DIVU,  32'd3,        32'd7,        32'd0,        EarlyLat0);
        add(1, MULDIV_OP_MUL,   32'd6,        32'd7,        32'd42,       3);
        add(1, MULDIV_OP_DIVU,  32'd100,      32'd7,        32'd14,       17);
        add(1, MULDIV_OP_MODU,  32'd100,      32'd7,        32'd2,        17);
        add(1, MULDIV_OP_DIVU,  32'd3,        32'd7,        32'd0,        EarlyLat1);
        add(1, MULDIV_OP_MODU,  32'd3,        32'd7,        32'd3,        EarlyLat1);
        add(1, MULDIV_OP_DIV,   32'hFFFFFF9C, 32'd7,        32'hFFFFFFF2, 17);
        add(1, MULDIV_OP_MOD,   32'hFFFFFF9C, 32'd7,        32'hFFFFFFFE, 17);

        foreach (vecs[i]) begin
            run_op(vecs[i].dut, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat,
                   $sformatf("vec%0d", i));
        end

        // Flush in the middle of a divide.
        @(negedge clk);
        drive(0, 1'b1, MULDIV_OP_DIV, 32'd100, 32'd3);
        @(negedge clk);
        drive(0, 1'b0, MULDIV_OP_MUL, '0, '0);
        repeat (10) @(negedge clk);
        check("flush busy before", rd(0, 3), 32'd1);
        flush0 = 1'b1;
        @(negedge clk);
        flush0 = 1'b0;
        check("flush ready after", rd(0, 0), 32'd1);
        check("flush busy after", rd(0, 3), 32'd0);
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (rd(0, 1) != 32'd0) seen++;
        end
        check("flush no resp", seen, 32'd0);
        run_op(0, MULDIV_OP_MUL, 32'd6, 32'd7, 32'd42, 2, "post-flush mul");

        // Flush in the accepting cycle drops the request.
        @(negedge clk);
        drive(0, 1'b1, MULDIV_OP_DIVU, 32'd9, 32'd2);
        flush0 = 1'b1;
        @(negedge clk);
        flush0 = 1'b0;
        drive(0, 1'b0, MULDIV_OP_MUL, '0, '0);
        check("accept-flush busy", rd(0, 3), 32'd0);
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (rd(0, 1) != 32'd0 || rd(0, 3) != 32'd0) seen++;
        end
        check("accept-flush idle", seen, 32'd0);

        // Backpressure, then a back-to-back request.
        @(negedge clk);
        drive(0, 1'b1, MULDIV_OP_MUL, 32'h1234, 32'h10);
        @(negedge clk);
        drive(0, 1'b1, MULDIV_OP_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF);
        wait_resp(0, k);
        check("bp latency", k, 32'd2);
        held = rd(0, 2);
        check("bp result", held, 32'h00012340);
        for (int c = 0; c < 5; c++) begin
            drive(0, 1'b1, MULDIV_OP_MULHU, 32'hFFFFFFFF - c, 32'hFFFFFFFF);
            @(negedge clk);
            check($sformatf("bp hold%0d", c), rd(0, 2), 32'h00012340);
            check($sformatf("bp notready%0d", c), rd(0, 0), 32'd0);
        end
        drive(0, 1'b1, MULDIV_OP_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF);
        set_rr(0, 1'b1);
        @(negedge clk);
        set_rr(0, 1'b0);
        check("bp release ready", rd(0, 0), 32'd1);
        check("bp release valid", rd(0, 1), 32'd0);
        @(negedge clk);
        drive(0, 1'b0, MULDIV_OP_MUL, '0, '0);
        check("b2b accepted", rd(0, 3), 32'd1);
        wait_resp(0, k);
        check("b2b latency", k, 32'd2);
        check("b2b result", rd(0, 2), 32'hFFFFFFFE);
        set_rr(0, 1'b1);
        @(negedge clk);
        set_rr(0, 1'b0);

        // Reset mid-divide on dut1 clears the held result as well.
        @(negedge clk);
        drive(1, 1'b1, MULDIV_OP_DIVU, 32'd1000, 32'd3);
        @(negedge clk);
        drive(1, 1'b0, MULDIV_OP_MUL, '0, '0);
        repeat (5) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midrst busy", rd(1, 3), 32'd0);
        check("midrst valid", rd(1, 1), 32'd0);
        check("midrst result", rd(1, 2), 32'd0);
        check("midrst ready", rd(1, 0), 32'd1);
        run_op(1, MULDIV_OP_DIVU, 32'd1000, 32'd3, 32'd333, 17, "post-reset div");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

endmodule
